// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rc4_pkg
// Desc     : Shared RC4 sequencer types, S-memory depth and key-byte helper.
// Revision : 1.0
// ============================================================================
package rc4_pkg;

    localparam int S_DEPTH    = 256;
    localparam int c_key_max  = 16;
    localparam int c_key_bits = 8 * c_key_max;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_INIT = 4'd1,
        ST_K_RI = 4'd2,
        ST_K_LI = 4'd3,
        ST_K_RJ = 4'd4,
        ST_K_LJ = 4'd5,
        ST_K_WI = 4'd6,
        ST_K_WJ = 4'd7,
        ST_PRGA = 4'd8,
        ST_DONE = 4'd9
    } rc4_state_e;

    // Key byte n lives at bits [8n+7:8n]; caller zero-extends the key to c_key_bits.
    function automatic logic [7:0] key_byte(input logic [c_key_bits-1:0] key,
                                            input logic [7:0]            idx);
        logic [c_key_bits-1:0] shifted;
        shifted = key >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_ksa.sv
`default_nettype none
// ============================================================================
// Module   : rc4_ksa
// Desc     : Fills S with the identity permutation, then runs the RC4 key
//            schedule through a single-port S interface. Pulses finish on exit.
// Revision : 1.0
// ============================================================================
module rc4_ksa
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] key,
    output logic [7:0]           s_addr,
    output logic [7:0]           s_wdata,
    output logic                 s_we,
    input  logic [7:0]           s_rdata,
    output logic                 finish
);

    rc4_state_e r_state;
    rc4_state_e w_state_nxt;
    logic [8:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_kidx;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic       w_last_i;

    assign w_last_i = (r_i == 9'(S_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_kidx  <= '0;
            r_si    <= '0;
            r_sj    <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_i    <= '0;
                        r_j    <= '0;
                        r_kidx <= '0;
                    end
                end
                ST_INIT: r_i <= w_last_i ? 9'd0 : r_i + 9'd1;
                ST_K_LI: begin
                    r_si <= s_rdata;
                    r_j  <= r_j + s_rdata + key_byte(c_key_bits'(key), r_kidx);
                end
                ST_K_LJ: r_sj <= s_rdata;
                ST_K_WJ: begin
                    // Key index is a wrapping counter so no modulo is needed.
                    r_kidx <= (r_kidx == 8'(KEY_LEN - 1)) ? 8'd0 : r_kidx + 8'd1;
                    r_i    <= r_i + 9'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_addr      = '0;
        s_wdata     = '0;
        s_we        = 1'b0;
        finish      = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_INIT;
            ST_INIT: begin
                s_we    = 1'b1;
                s_addr  = r_i[7:0];
                s_wdata = r_i[7:0];
                if (w_last_i) w_state_nxt = ST_K_RI;
            end
            ST_K_RI: begin
                s_addr      = r_i[7:0];
                w_state_nxt = ST_K_LI;
            end
            ST_K_LI: w_state_nxt = ST_K_RJ;
            ST_K_RJ: begin
                s_addr      = r_j;
                w_state_nxt = ST_K_LJ;
            end
            ST_K_LJ: w_state_nxt = ST_K_WI;
            ST_K_WI: begin
                s_we        = 1'b1;
                s_addr      = r_i[7:0];
                s_wdata     = r_sj;
                w_state_nxt = ST_K_WJ;
            end
            ST_K_WJ: begin
                s_we    = 1'b1;
                s_addr  = r_j;
                s_wdata = r_si;
                if (w_last_i) begin
                    finish      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_K_RI;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rc4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rc4_ctrl
// Desc     : RC4 sequencer: key schedule via rc4_ksa, then hands S to the prng
//            and XORs each keystream byte with the message into ciphertext RAM.
// Revision : 1.0
// ============================================================================
module rc4_ctrl
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 3,
    parameter int MSG_LEN = 32,
    localparam int c_k_w  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] secret_key,
    output logic [7:0]           s_addr,
    output logic [7:0]           s_wdata,
    output logic                 s_we,
    input  logic [7:0]           s_rdata,
    output logic                 s_grant_prng,
    output logic                 key_gen,
    input  logic                 byte_done,
    input  logic [7:0]           cipherkey,
    output logic [c_k_w-1:0]     msg_addr,
    input  logic [7:0]           msg_data,
    output logic [c_k_w-1:0]     ct_addr,
    output logic [7:0]           ct_data,
    output logic                 ct_we,
    output logic                 busy,
    output logic                 done
);

    rc4_state_e           r_state;
    rc4_state_e           w_state_nxt;
    logic [8*KEY_LEN-1:0] r_key;
    logic [c_k_w-1:0]     r_k;
    logic                 r_byte_done_q;
    logic                 w_accept;
    logic                 w_rise;
    logic                 w_last;
    logic                 w_ksa_start;
    logic                 w_ksa_finish;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_rise   = byte_done && !r_byte_done_q;
    assign w_last   = (r_k == c_k_w'(MSG_LEN - 1));

    rc4_ksa #(
        .KEY_LEN (KEY_LEN)
    ) u_ksa (
        .clk     (clk),
        .rst     (rst),
        .start   (w_ksa_start),
        .key     (r_key),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_we    (s_we),
        .s_rdata (s_rdata),
        .finish  (w_ksa_finish)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_key         <= '0;
            r_k           <= '0;
            r_byte_done_q <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_byte_done_q <= byte_done;
            if (w_accept) begin
                r_key <= secret_key;
                r_k   <= '0;
            end else if ((r_state == ST_PRGA) && w_rise) begin
                r_k <= r_k + c_k_w'(1);
            end
        end
    end

    // byte_done stays high two cycles; only its rising edge commits a byte.
    always_comb begin
        w_state_nxt = r_state;
        w_ksa_start = 1'b0;
        key_gen     = 1'b0;
        ct_we       = 1'b0;
        ct_data     = '0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_ksa_start = 1'b1;
                    w_state_nxt = ST_INIT;
                end
            end
            ST_INIT: if (w_ksa_finish) w_state_nxt = ST_PRGA;
            ST_PRGA: begin
                key_gen = 1'b1;
                if (w_rise) begin
                    ct_we   = 1'b1;
                    ct_data = msg_data ^ cipherkey;
                    if (w_last) begin
                        key_gen     = 1'b0;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign s_grant_prng = (r_state == ST_PRGA);
    assign busy         = (r_state == ST_INIT) || (r_state == ST_PRGA);
    assign done         = (r_state == ST_DONE);
    assign msg_addr     = r_k;
    assign ct_addr      = r_k;

endmodule
`default_nettype wire

// File: tb/tb_rc4_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc4_ctrl
// Desc     : Self-checking bench: S memory, message ROM and prng models around
//            two rc4_ctrl instances (MSG_LEN 9 and 1), ciphertext scoreboard.
// Revision : 1.0
// ============================================================================
module tb_rc4_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [23:0]      secret_key;
    logic [1:0]       start;
    logic [1:0][7:0]  s_addr, s_wdata, s_rdata, cipherkey, msg_data, ct_data;
    logic [1:0][3:0]  msg_addr, ct_addr;
    logic [1:0]       s_we, s_grant_prng, key_gen, byte_done, ct_we, busy, done, prng_calc;

    logic [7:0] msg    [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct_ref [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    for (genvar u = 0; u < 2; u++) begin : g_env
        localparam int ML = (u == 0) ? 9 : 1;
        localparam int AW = (ML > 1) ? $clog2(ML) : 1;
        logic [AW-1:0] msg_a, ct_a;
        logic [7:0] mem [256];
        logic [7:0] rdata = 8'h00, mdata = 8'h00, ks = 8'h00;
        logic [7:0] pi = 8'h00, pj = 8'h00;
        logic       bd = 1'b0;
        int unsigned pst = 0, cnt = 0;
        logic [7:0] ni, si, nj, sj, t, ksn;

        // Behavioural prng: one RC4 PRGA step per byte, byte_done high 2 cycles.
        assign ni  = pi + 8'd1;
        assign si  = mem[ni];
        assign nj  = pj + si;
        assign sj  = mem[nj];
        assign t   = si + sj;
        assign ksn = (t == ni) ? sj : ((t == nj) ? si : mem[t]);

        rc4_ctrl #(.KEY_LEN(3), .MSG_LEN(ML)) u_dut (
            .clk(clk), .rst(rst), .start(start[u]), .secret_key(secret_key),
            .s_addr(s_addr[u]), .s_wdata(s_wdata[u]), .s_we(s_we[u]), .s_rdata(s_rdata[u]),
            .s_grant_prng(s_grant_prng[u]), .key_gen(key_gen[u]), .byte_done(byte_done[u]),
            .cipherkey(cipherkey[u]), .msg_addr(msg_a), .msg_data(msg_data[u]),
            .ct_addr(ct_a), .ct_data(ct_data[u]), .ct_we(ct_we[u]), .busy(busy[u]), .done(done[u])
        );

        assign s_rdata[u]   = rdata;
        assign msg_data[u]  = mdata;
        assign cipherkey[u] = ks;
        assign byte_done[u] = bd;
        assign msg_addr[u]  = 4'(msg_a);
        assign ct_addr[u]   = 4'(ct_a);
        assign prng_calc[u] = (pst == 1) && (cnt == 2);

        always @(posedge clk) begin
            if (s_we[u]) mem[s_addr[u]] <= s_wdata[u];
            rdata <= mem[s_addr[u]];
            mdata <= (int'(msg_a) < 9) ? msg[msg_a] : 8'h00;
            case (pst)
                0: begin
                    if (key_gen[u]) begin pst <= 1; cnt <= 0; end
                    else begin pi <= 8'h00; pj <= 8'h00; end
                end
                1: begin
                    if (cnt == 2) begin
                        if (s_grant_prng[u]) begin
                            mem[ni] <= sj;
                            mem[nj] <= si;
                        end
                        pi <= ni; pj <= nj; ks <= ksn; bd <= 1'b1; pst <= 2;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                2: pst <= 3;
                default: begin bd <= 1'b0; pst <= 0; end
            endcase
        end
    end

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ct(input int u);
        logic [15:0] e;
        e = 16'hFFFF;
        if (u == 0) begin if (q0.size() > 0) e = q0.pop_front(); end
        else begin if (q1.size() > 0) e = q1.pop_front(); end
        chk($sformatf("ct_write%0d", u), {4'h0, ct_addr[u], ct_data[u]}, e);
    endtask

    task automatic tick();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            if (ct_we[u]) check_ct(u);
            if (busy[u] && !s_grant_prng[u]) chk("key_gen_in_ksa", key_gen[u], 0);
            if (prng_calc[u]) chk("grant_at_prng", s_grant_prng[u], 1);
        end
    endtask

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
    endtask

    task automatic push_ct(input int u, input int n);
        for (int b = 0; b < n; b++) begin
            if (u == 0) q0.push_back({4'h0, 4'(b), ct_ref[b]});
            else        q1.push_back({4'h0, 4'(b), ct_ref[b]});
        end
    endtask

    task automatic wait_done(input int u);
        for (int n = 0; n < 4000 && done[u] !== 1'b1; n++) tick();
        chk($sformatf("done%0d", u), done[u], 1);
    endtask

    task automatic check_reset_outs(input int u);
        chk($sformatf("reset_outs%0d", u),
            {s_we[u], ct_we[u], key_gen[u], s_grant_prng[u], busy[u], done[u],
             s_addr[u], s_wdata[u], msg_addr[u], ct_addr[u], ct_data[u]}, 0);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 2'b00;
        secret_key = 24'h79654B;
        repeat (3) tick();
        check_reset_outs(0);
        check_reset_outs(1);
        rst = 1'b0;
        tick();

        // Identity fill on cycles 1..256, then the "Key"/"Plaintext" vector
        push_ct(0, 9);
        pulse_start(0);
        chk("busy_after_start", busy[0], 1);
        for (int n = 0; n < 256; n++) begin
            chk("init_write", {s_we[0], s_addr[0], s_wdata[0]}, {1'b1, 8'(n), 8'(n)});
            tick();
        end
        chk("init_end_we", s_we[0], 0);
        wait_done(0);
        chk("q0_drained_vec", q0.size(), 0);

        // Start and key changes while busy are ignored
        push_ct(0, 9);
        pulse_start(0);
        repeat (600) tick();
        secret_key = 24'hFFFFFF;
        pulse_start(0);
        chk("busy_ignored_ksa", {busy[0], done[0]}, 2'b10);
        for (int n = 0; n < 3000 && !s_grant_prng[0]; n++) tick();
        chk("grant_reached", s_grant_prng[0], 1);
        repeat (8) tick();
        secret_key = 24'h000000;
        pulse_start(0);
        chk("busy_ignored_prga", {busy[0], done[0]}, 2'b10);
        secret_key = 24'h79654B;
        wait_done(0);
        chk("q0_drained_busy", q0.size(), 0);

        // Reset mid-keystream
        push_ct(0, 9);
        pulse_start(0);
        for (int n = 0; n < 3000 && q0.size() > 6; n++) tick();
        chk("mid_stream_reached", q0.size(), 6);
        rst = 1'b1;
        tick();
        tick();
        q0.delete();
        check_reset_outs(0);
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("quiet_after_rst", {s_we[0], ct_we[0], busy[0]}, 0);
        end

        // Abort at KSA iteration 100, then a clean run
        pulse_start(0);
        repeat (256 + 6 * 100) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("abort_idle", {busy[0], done[0]}, 0);
        push_ct(0, 9);
        pulse_start(0);
        wait_done(0);
        chk("q0_drained_abort", q0.size(), 0);

        // Single-byte message, then back-to-back restart from DONE
        push_ct(1, 1);
        pulse_start(1);
        for (int n = 0; n < 4000 && !ct_we[1]; n++) tick();
        chk("len1_ct_we", ct_we[1], 1);
        chk("len1_kg_rise", key_gen[1], 0);
        tick();
        chk("len1_kg_after", key_gen[1], 0);
        chk("len1_done", done[1], 1);
        repeat (20) tick();
        chk("q1_drained", q1.size(), 0);
        push_ct(1, 1);
        pulse_start(1);
        chk("restart_done_clr", {busy[1], done[1]}, 2'b10);
        wait_done(1);
        chk("q1_drained_restart", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
